alu_core: RTL and testbench

Arithmetic stage directly downstream of the B-bus multiplexer in the convolution processor datapath. It combines the selected B-bus operand (pixel, kernel coefficient, MDR, etc.) with the A-bus operand (accumulator side) and drives the C bus and zero flag consumed by the register file and control unit. Single-cycle operations complete in one clock. MUL uses a multi-cycle shift-add sequencer for kernel × pixel products, with a start/busy/done handshake to the control unit.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_core_shift_add_multiplier.sv | 54 +++++
 rtl/alu_core.sv | 109 ++++++++++
 tb/tb_alu_core.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, state and sizing definitions for the convolution-datapath ALU.
package alu_pkg;

    localparam int ALU_WIDTH    = 32;
    localparam int ALU_MUL_BITS = 16;

    typedef enum logic [2:0] {
        ALU_PASS_B = 3'b000,
        ALU_ADD    = 3'b001,
        ALU_SUB    = 3'b010,
        ALU_MULU   = 3'b011,
        ALU_INC_A  = 3'b100,
        ALU_SHR_B  = 3'b101,
        ALU_CLR    = 3'b110,
        ALU_PASS_A = 3'b111
    } alu_op_t;

    typedef enum logic {
        ALU_IDLE = 1'b0,
        ALU_MUL  = 1'b1
    } alu_state_t;

endpackage

// File: rtl/alu_core_shift_add_multiplier.sv
// Iterative unsigned shift-add multiplier: one multiplier bit consumed per busy cycle.
module shift_add_multiplier #(
    parameter int MUL_BITS = 16
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  load,
    input  logic                  busy,
    input  logic [MUL_BITS-1:0]   a_in,
    input  logic [MUL_BITS-1:0]   b_in,
    output logic                  last,
    output logic [2*MUL_BITS-1:0] product
);

    localparam int PW = 2 * MUL_BITS;
    localparam int CW = (MUL_BITS > 1) ? $clog2(MUL_BITS) : 1;

    logic [PW-1:0]       mcand_reg;
    logic [MUL_BITS-1:0] mplier_reg;
    logic [PW-1:0]       prod_reg;
    logic [CW-1:0]       count_reg;
    logic [PW-1:0]       addend;

    // Partial product for this step: multiplicand gated by the current multiplier LSB.
    generate
        for (genvar gi = 0; gi < PW; gi++) begin : g_addend
            assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
        end
    endgenerate

    // product already includes the current step, so the caller can capture it on the last cycle.
    assign product = prod_reg + addend;
    assign last    = busy && (count_reg == '0);

    always_ff @(posedge clk) begin
        if (srst) begin
            mcand_reg  <= '0;
            mplier_reg <= '0;
            prod_reg   <= '0;
            count_reg  <= '0;
        end else if (load) begin
            mcand_reg  <= {{MUL_BITS{1'b0}}, a_in};
            mplier_reg <= b_in;
            prod_reg   <= '0;
            count_reg  <= CW'(MUL_BITS - 1);
        end else if (busy) begin
            prod_reg   <= product;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            count_reg  <= count_reg - CW'(1);
        end
    end

endmodule

// File: rtl/alu_core.sv
// ALU stage between the B-bus mux and the C bus: single-cycle ops plus a multi-cycle MUL.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH    = ALU_WIDTH,
    parameter int MUL_BITS = ALU_MUL_BITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] a_bus,
    input  logic [WIDTH-1:0] b_bus,
    output logic [WIDTH-1:0] c_bus,
    output logic             z_flag,
    output logic             busy,
    output logic             done
);

    alu_state_t state_reg, state_next;

    logic [WIDTH-1:0]      c_bus_reg;
    logic                  z_flag_reg;
    logic                  done_reg;
    logic [WIDTH-1:0]      op_result;
    logic [WIDTH-1:0]      result_next;
    logic                  result_we;
    logic                  mul_load;
    logic                  mul_last;
    logic [2*MUL_BITS-1:0] mul_product;

    shift_add_multiplier #(
        .MUL_BITS(MUL_BITS)
    ) u_mul (
        .clk    (clk),
        .srst   (rst),
        .load   (mul_load),
        .busy   (busy),
        .a_in   (a_bus[MUL_BITS-1:0]),
        .b_in   (b_bus[MUL_BITS-1:0]),
        .last   (mul_last),
        .product(mul_product)
    );

    always_comb begin
        op_result = '0;
        case (alu_op)
            ALU_PASS_B: op_result = b_bus;
            ALU_ADD:    op_result = a_bus + b_bus;
            ALU_SUB:    op_result = a_bus - b_bus;
            ALU_INC_A:  op_result = a_bus + WIDTH'(1);
            ALU_SHR_B:  op_result = b_bus >> 1;
            ALU_CLR:    op_result = '0;
            ALU_PASS_A: op_result = a_bus;
            default:    op_result = '0;
        endcase
    end

    // Requests are only looked at in IDLE, so a start during MUL (including its last cycle) is dropped.
    always_comb begin
        state_next  = state_reg;
        mul_load    = 1'b0;
        result_we   = 1'b0;
        result_next = '0;
        case (state_reg)
            ALU_IDLE: begin
                if (start) begin
                    if (alu_op == ALU_MULU) begin
                        mul_load   = 1'b1;
                        state_next = ALU_MUL;
                    end else begin
                        result_we   = 1'b1;
                        result_next = op_result;
                    end
                end
            end
            ALU_MUL: begin
                if (mul_last) begin
                    result_we   = 1'b1;
                    result_next = WIDTH'(mul_product);
                    state_next  = ALU_IDLE;
                end
            end
            default: state_next = ALU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ALU_IDLE;
            c_bus_reg  <= '0;
            z_flag_reg <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= result_we;
            if (result_we) begin
                c_bus_reg  <= result_next;
                z_flag_reg <= (result_next == '0);
            end
        end
    end

    assign c_bus  = c_bus_reg;
    assign z_flag = z_flag_reg;
    assign done   = done_reg;
    assign busy   = (state_reg == ALU_MUL);

endmodule

// File: tb/tb_alu_core.sv
// Scoreboard bench for alu_core: expected results queued at issue, checked when done pulses.
module tb_alu_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  alu_op;
    logic [31:0] a_bus;
    logic [31:0] b_bus;
    logic [31:0] c_bus;
    logic        z_flag;
    logic        busy;
    logic        done;

    typedef struct {
        logic [31:0] c;
        logic        z;
        int          cyc;
        logic [2:0]  op;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    alu_core dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .alu_op(alu_op),
        .a_bus (a_bus),
        .b_bus (b_bus),
        .c_bus (c_bus),
        .z_flag(z_flag),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every done pulse must match the oldest outstanding expectation, at the expected cycle.
    always @(negedge clk) begin
        if (done) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done: got done c_bus=%h at cyc %0d, required no done", c_bus, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (c_bus !== e.c || z_flag !== e.z || cyc != e.cyc) begin
                    n_err++;
                    $display("FAIL result op=%0d: got c_bus=%h z=%b cyc=%0d, required c_bus=%h z=%b cyc=%0d",
                             e.op, c_bus, z_flag, cyc, e.c, e.z, e.cyc);
                end else begin
                    $display("done op=%0d c_bus=%h z=%b cyc=%0d ok", e.op, c_bus, z_flag, cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ec, input logic ez, input int lat);
        exp_t e;
        @(negedge clk);
        start  = 1'b1;
        alu_op = op;
        a_bus  = a;
        b_bus  = b;
        e.c    = ec;
        e.z    = ez;
        e.cyc  = cyc + lat;
        e.op   = op;
        sb.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        alu_op = 3'd0;
        a_bus  = '0;
        b_bus  = '0;
        repeat (3) @(negedge clk);
        check("reset_c_bus", c_bus, 32'h0);
        check("reset_z_flag", {31'd0, z_flag}, 32'h0);
        check("reset_busy", {31'd0, busy}, 32'h0);
        check("reset_done", {31'd0, done}, 32'h0);
        rst = 1'b0;

        // ADD wraps; done must be a single-cycle pulse and c_bus must hold afterwards
        issue(3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b0, 1);
        idle();
        @(negedge clk);
        check("add_done_pulse", {31'd0, done}, 32'h0);
        check("add_c_hold", c_bus, 32'h0000_0001);

        // SUB to zero, then PASS_B
        issue(3'b010, 32'h1234_5678, 32'h1234_5678, 32'h0, 1'b1, 1);
        issue(3'b000, 32'h0, 32'h8888_8888, 32'h8888_8888, 1'b0, 1);
        idle();
        idle();

        // MUL 0xFFFF x 0xFFFF with junk upper bits and buses scrambled after start
        issue(3'b011, 32'hA1A2_FFFF, 32'hA1A2_FFFF, 32'hFFFE_0001, 1'b0, 17);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            start = 1'b0;
            a_bus = $urandom;
            b_bus = $urandom;
            check($sformatf("mul_busy_%0d", i), {31'd0, busy}, 32'h1);
        end
        @(negedge clk);
        check("mul_busy_end", {31'd0, busy}, 32'h0);
        idle();

        // MUL 3 x 5 with ADD requests during busy and on the final MUL cycle
        issue(3'b011, 32'h3, 32'h5, 32'h0000_000F, 1'b0, 17);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 4 || i == 16) begin
                start  = 1'b1;
                alu_op = 3'b001;
                a_bus  = 32'h1;
                b_bus  = 32'h1;
            end else begin
                start = 1'b0;
            end
        end
        idle();

        // Reset in the middle of a MUL aborts it without a done
        issue(3'b011, 32'h1234, 32'h0010, 32'h0001_2340, 1'b0, 17);
        repeat (7) idle();
        @(negedge clk);
        rst = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        rst = 1'b0;
        check("abort_c_bus", c_bus, 32'h0);
        check("abort_busy", {31'd0, busy}, 32'h0);
        check("abort_done", {31'd0, done}, 32'h0);
        repeat (20) idle();
        issue(3'b101, 32'h0, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1);
        idle();
        idle();

        // Back-to-back INC_A, CLR, PASS_A
        issue(3'b100, 32'h0, 32'h0, 32'h1, 1'b0, 1);
        issue(3'b110, 32'h0, 32'h0, 32'h0, 1'b1, 1);
        issue(3'b111, 32'hB1B2_B3B4, 32'h0, 32'hB1B2_B3B4, 1'b0, 1);
        idle();
        repeat (3) idle();

        // Reset and start on the same edge: request dropped
        @(negedge clk);
        rst    = 1'b1;
        start  = 1'b1;
        alu_op = 3'b001;
        a_bus  = 32'h1;
        b_bus  = 32'h1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("rst_start_c_bus", c_bus, 32'h0);
        check("rst_start_done", {31'd0, done}, 32'h0);
        repeat (4) idle();

        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL missing_done: got %0d outstanding results, required 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
